// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: sequential PC generation, single-outstanding
// instruction memory reads, and a small FIFO of {pc, word} for decode.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   redirect_valid/_pc  reload fetch PC, flush FIFO, drop in-flight response
//   mem_req/mem_addr    read request, held until mem_ack
//   mem_ack/mem_rdata   read response
//   inst_valid/_data/_pc/inst_ready  FIFO head handshake towards decode
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;

    logic [31:0]   data_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic          push;
    logic          pop;
    logic          room;
    logic [CW-1:0] cnt_push;
    logic          unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    assign push = (state_q == REQ) && mem_ack && !redirect_valid;
    assign pop  = inst_valid && inst_ready && !redirect_valid;

    // Occupancy after this cycle's push; a new request needs a free slot.
    assign cnt_push = count_q + CW'(1) - CW'(pop);
    assign room     = cnt_push < CW'(DEPTH);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!redirect_valid && count_q < CW'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    state_d = mem_ack ? IDLE : DROP;
                end else if (mem_ack && !room) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_req  = (state_q != IDLE);
        mem_addr = addr_q;
    end

    // Fetch PC, request address and FIFO bookkeeping
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // A fresh request starts from IDLE or right after an accepted ack.
        if (state_d == REQ && (state_q == IDLE || mem_ack)) begin
            addr_d = fetch_pc_d;
        end

        if (redirect_valid) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            count_d = count_q + CW'(push) - CW'(pop);
            wptr_d  = wptr_q + AW'(push);
            rptr_d  = rptr_q + AW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= mem_rdata;
            pc_mem[wptr_q]   <= fetch_pc_q;
        end
    end

    always_comb begin
        inst_valid = (count_q != '0);
        inst_data  = inst_valid ? data_mem[rptr_q] : '0;
        inst_pc    = inst_valid ? pc_mem[rptr_q] : '0;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed tests, memory responder model,
// scoreboard queues for request addresses and delivered instructions.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int lat    = 0;
    int budget = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_inst[$];

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5C3_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic bad(input string nm, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got %h want nothing", nm, act);
    endtask

    // Memory: acks after lat wait cycles, only while budget remains.
    initial begin
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && budget > 0) begin
                if (cnt >= lat) begin
                    mem_ack = 1'b1;
                    mem_rdata = word(mem_addr);
                    cnt = 0;
                    budget--;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: checks every accepted request and every delivered instruction.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (mem_req && mem_ack) begin
                if (exp_addr.size() == 0) bad("extra_req", mem_addr);
                else begin
                    e = exp_addr.pop_front();
                    chk("req_addr", mem_addr, e);
                end
            end
            if (inst_valid && inst_ready) begin
                if (exp_inst.size() == 0) bad("extra_inst", inst_pc);
                else begin
                    e = exp_inst.pop_front();
                    chk("inst_pc", inst_pc, e);
                    chk("inst_data", inst_data, word(e));
                end
            end
        end
    end

    task automatic drain(input string nm);
        int k;
        k = 0;
        while ((exp_addr.size() + exp_inst.size()) != 0 && k < 100) begin
            @(negedge clk);
            #4;
            k++;
        end
        chk(nm, exp_addr.size() + exp_inst.size(), 0);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b0;
        budget = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_addr(input logic [31:0] a);
        int k;
        k = 0;
        while (!(mem_req && mem_addr == a) && k < 50) begin
            @(negedge clk);
            #4;
            k++;
        end
        if (k >= 50) bad("wait_addr_timeout", a);
    endtask

    task automatic exp_both(input logic [31:0] a);
        exp_addr.push_back(a);
        exp_inst.push_back(a);
    endtask

    initial begin
        #1 reset = 1'b0;
        @(negedge clk);
        #4;
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);

        // 1: zero-wait streaming
        @(negedge clk);
        lat = 0;
        inst_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_both(32'(i * 4));
        budget = 8;
        reset = 1'b1;
        drain("t1_drain");

        // 2: backpressure fills the queue, then resumes
        hold_reset();
        lat = 0;
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_addr.push_back(32'(i * 4));
        budget = 100;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        #4;
        chk("t2_full_req", 32'(mem_req), 0);
        chk("t2_full_valid", 32'(inst_valid), 1);
        chk("t2_head_pc", inst_pc, 32'h0);
        chk("t2_head_data", inst_data, 32'hA5C3_0000);
        @(negedge clk);
        budget = 4;
        for (int i = 4; i < 8; i++) exp_addr.push_back(32'(i * 4));
        for (int i = 0; i < 8; i++) exp_inst.push_back(32'(i * 4));
        inst_ready = 1'b1;
        drain("t2_drain");

        // 3: redirect while a slow request is pending
        hold_reset();
        lat = 3;
        inst_ready = 1'b0;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'h100);
        exp_inst.push_back(32'h100);
        budget = 4;
        reset = 1'b1;
        wait_addr(32'h8);
        chk("t3_pre_valid", 32'(inst_valid), 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        chk("t3_drop_req", 32'(mem_req), 1);
        chk("t3_drop_addr", mem_addr, 32'h8);
        chk("t3_flush", 32'(inst_valid), 0);
        @(negedge clk);
        #4;
        chk("t3_hold_addr", mem_addr, 32'h8);
        inst_ready = 1'b1;
        drain("t3_drain");

        // 4: redirect coincides with ack and pop; low bits forced to 00
        hold_reset();
        lat = 0;
        inst_ready = 1'b1;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        exp_addr.push_back(32'h200);
        exp_inst.push_back(32'h0);
        exp_inst.push_back(32'h4);
        exp_inst.push_back(32'h200);
        budget = 4;
        reset = 1'b1;
        wait_addr(32'h8);
        chk("t4_pre_valid", 32'(inst_valid), 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        redirect_valid = 1'b0;
        #4;
        chk("t4_flush", 32'(inst_valid), 0);
        chk("t4_idle", 32'(mem_req), 0);
        @(negedge clk);
        #4;
        chk("t4_new_req", 32'(mem_req), 1);
        chk("t4_new_addr", mem_addr, 32'h200);
        drain("t4_drain");

        // 5: redirect from IDLE and address wrap
        hold_reset();
        lat = 0;
        inst_ready = 1'b1;
        exp_both(32'hFFFF_FFFC);
        exp_both(32'h0);
        exp_both(32'h4);
        budget = 3;
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        drain("t5_drain");

        // 6: asynchronous reset mid-request
        hold_reset();
        lat = 0;
        inst_ready = 1'b0;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        budget = 2;
        reset = 1'b1;
        repeat (6) @(negedge clk);
        #4;
        chk("t6_pre_req", 32'(mem_req), 1);
        chk("t6_pre_valid", 32'(inst_valid), 1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_req", 32'(mem_req), 0);
        chk("t6_async_valid", 32'(inst_valid), 0);
        chk("t6_async_addr", mem_addr, 0);
        chk("t6_async_pc", inst_pc, 0);
        @(negedge clk);
        exp_both(32'h0);
        exp_both(32'h4);
        inst_ready = 1'b1;
        budget = 2;
        reset = 1'b1;
        @(negedge clk);
        #4;
        chk("t6_restart_req", 32'(mem_req), 1);
        chk("t6_restart_addr", mem_addr, 32'h0);
        chk("t6_restart_empty", 32'(inst_valid), 0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
